// File: rtl/hilo_muldiv_unit.sv
// Iterative radix-2 multiply/divide engine owning the architectural HI/LO pair.
// Start/Busy/Done handshake; MT ops and divide-by-zero complete on the accept edge.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   op_mag_q, op_mag_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, dbz_q, dbz_d;

  logic               is_div_in, is_signed_in, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH:0]   div_shift;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix, hilo;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_div_in    = (Op[2:1] == 2'b01);
  assign is_signed_in = (Op == OP_MULT) || (Op == OP_DIV) || Op[2];
  assign a_neg        = is_signed_in && A[WIDTH-1];
  assign b_neg        = is_signed_in && B[WIDTH-1];
  // Two's-complement negation of the most negative value yields 2^(WIDTH-1) unsigned.
  assign a_mag        = a_neg ? -A : A;
  assign b_mag        = b_neg ? -B : B;

  // Multiply: acc = {partial, multiplier}, shift right with the carry of each add.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, op_mag_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}, restore when the trial borrows.
  assign div_shift = {acc_q, 1'b0};
  assign div_trial = div_shift[2*WIDTH:WIDTH] - {1'b0, op_mag_q};
  assign div_next  = div_trial[WIDTH] ? div_shift[2*WIDTH-1:0]
                                      : {div_trial[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign hilo     = {hi_q, lo_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    op_mag_d  = op_mag_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (Op == OP_MTHI) begin
            hi_d   = A;
            done_d = 1'b1;
          end else if (Op == OP_MTLO) begin
            lo_d   = A;
            done_d = 1'b1;
          end else if (is_div_in && (B == '0)) begin
            hi_d   = A;
            lo_d   = '1;
            done_d = 1'b1;
            dbz_d  = 1'b1;
          end else begin
            op_d      = Op;
            cnt_d     = '0;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            op_mag_d  = is_div_in ? b_mag : a_mag;
            acc_d     = {{WIDTH{1'b0}}, (is_div_in ? a_mag : b_mag)};
            state_d   = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d = (op_q[2:1] == 2'b01) ? div_next : mul_next;
        if (cnt_q == LAST_STEP) state_d = S_FIX;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      S_FIX: begin
        case (op_q)
          OP_DIV, OP_DIVU: begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
          OP_MADD: {hi_d, lo_d} = hilo + prod_fix;
          OP_MSUB: {hi_d, lo_d} = hilo - prod_fix;
          default: {hi_d, lo_d} = prod_fix;
        endcase
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      op_mag_q  <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      op_mag_q  <= op_mag_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign Busy      = (state_q != S_IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: expected HI/LO/DivByZero are queued at
// Start and popped when Done rises; a second instance covers WIDTH=8.
module tb_hilo_muldiv_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  logic        start8 = 1'b0;
  logic [2:0]  op8 = 3'b000;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .Op(op), .A(a), .B(b),
    .Busy(busy), .Done(done), .DivByZero(dbz), .HI(hi), .LO(lo)
  );

  hilo_muldiv_unit #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset(rst), .Start(start8), .Op(op8), .A(a8), .B(b8),
    .Busy(busy8), .Done(done8), .DivByZero(dbz8), .HI(hi8), .LO(lo8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge. Edge counts include the accept edge; busy_n counts
  // Busy-high samples. With noise set, a junk DIVU request is offered every
  // cycle while the engine is working.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] ia,
                       input logic [31:0] ib, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edbz, input int eedges, input int ebusy, input bit noise);
    exp_t        e;
    int          edges;
    int          busy_n;
    logic [31:0] hi0, lo0;
    bit          held;
    e.hi = ehi; e.lo = elo; e.dbz = edbz;
    sb.push_back(e);
    hi0 = hi; lo0 = lo; held = 1'b1;
    start = 1'b1; op = o; a = ia; b = ib;
    edges = 0; busy_n = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (busy) busy_n++;
      if (!done && (hi !== hi0 || lo !== lo0)) held = 1'b0;
      if (done || !noise) start = 1'b0;
      else begin
        start = 1'b1; op = 3'b011; a = 32'd1; b = 32'd1;
      end
    end while (!done && edges < 200);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " edges"}, 64'(edges), 64'(eedges));
    check({tag, " busy_cycles"}, 64'(busy_n), 64'(ebusy));
    check({tag, " busy_low_at_done"}, 64'(busy), 64'd0);
    check({tag, " hilo_held"}, 64'(held), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, " HI"}, 64'(hi), 64'(e.hi));
      check({tag, " LO"}, 64'(lo), 64'(e.lo));
      check({tag, " DivByZero"}, 64'(dbz), 64'(e.dbz));
    end else begin
      errors++;
      $error("FAIL %s scoreboard: observed=empty expected=entry", tag);
    end
  endtask

  initial begin
    int edges8;
    int extra_done;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset HI", 64'(hi), 64'd0);
    check("reset LO", 64'(lo), 64'd0);
    check("reset Busy", 64'(busy), 64'd0);
    check("reset Done", 64'(done), 64'd0);

    // Abort a MULT 7x9 mid-run with a two-cycle reset.
    start = 1'b1; op = 3'b000; a = 32'd7; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("midrun Busy", 64'(busy), 64'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("abort Busy", 64'(busy), 64'd0);
    check("abort HILO", {hi, lo}, 64'd0);
    check("abort Done", 64'(done), 64'd0);

    // Iterative ops: accept edge plus WIDTH+1 edges, Busy high WIDTH+1 cycles.
    do_op("mtlo5", 3'b111, 32'd5, 32'd0, 32'h0, 32'h5, 1'b0, 1, 0, 0);
    do_op("mult", 3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, 33, 0);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    do_op("multu", 3'b001, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB, 1'b0, 34, 33, 0);
    do_op("div_m7_2", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 33, 0);
    do_op("div_m7_m2", 3'b010, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3, 1'b0, 34, 33, 0);
    do_op("divu_100_7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 33, 0);
    do_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 34, 33, 0);
    do_op("divu_by0", 3'b011, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b1, 1, 0, 0);
    @(negedge clk);
    check("dbz_pulse", 64'(dbz), 64'd0);
    do_op("div_by0", 3'b010, 32'hFFFFFF00, 32'd0, 32'hFFFFFF00, 32'hFFFFFFFF, 1'b1, 1, 0, 0);

    do_op("mthi0", 3'b110, 32'd0, 32'd0, 32'h0, 32'hFFFFFFFF, 1'b0, 1, 0, 0);
    do_op("mtlo1s", 3'b111, 32'hFFFFFFFF, 32'd0, 32'h0, 32'hFFFFFFFF, 1'b0, 1, 0, 0);
    do_op("madd", 3'b100, 32'd1, 32'd1, 32'd1, 32'd0, 1'b0, 34, 33, 0);
    do_op("msub", 3'b101, 32'd2, 32'd3, 32'd0, 32'hFFFFFFFA, 1'b0, 34, 33, 0);

    // Junk Starts during the run are ignored; MTHI is accepted in the Done cycle.
    do_op("mult_noise", 3'b000, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 34, 33, 1);
    do_op("b2b_mthi", 3'b110, 32'd9, 32'd0, 32'd9, 32'd12, 1'b0, 1, 0, 0);
    extra_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    check("no_queued_done", 64'(extra_done), 64'd0);
    check("idle HILO", {hi, lo}, {32'd9, 32'd12});

    // WIDTH=8: -128 * -128 = 0x4000.
    start8 = 1'b1; op8 = 3'b000; a8 = 8'h80; b8 = 8'h80;
    edges8 = 0;
    do begin
      @(posedge clk);
      edges8++;
      @(negedge clk);
      start8 = 1'b0;
    end while (!done8 && edges8 < 50);
    check("w8 done", 64'(done8), 64'd1);
    check("w8 edges", 64'(edges8), 64'd10);
    check("w8 HILO", 64'({hi8, lo8}), 64'h4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
